wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters.
  - Pipeline writeback: the output of the memory/writeback pipeline register.
  - Long-latency unit (LU), e.g. the divider or the load-miss return.
- Pipeline has priority. LU results wait in a small in-order queue.
- A starvation counter forces an LU drain by stalling the pipeline writeback for one cycle.
- Sits between the MW pipeline register and the register file; drives the MW hold (stall) request.

Parameters:
- XLEN, 32, data width of write-back value
- REGW, 5, register index width
- QDEPTH, 2, LU result queue depth (power of two, >=2)
- MAX_WAIT, 4, consecutive cycles a non-empty queue may be denied before forced drain (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pipe_we  in  1  pipeline writeback write enable
- pipe_rd  in  REGW  pipeline destination register
- pipe_data  in  XLEN  pipeline writeback data
- pipe_stall  out  1  combinational; 1 = pipeline writeback not accepted this cycle, MW must hold and re-present
- lu_valid  in  1  LU result valid
- lu_rd  in  REGW  LU destination register
- lu_data  in  XLEN  LU result data
- lu_ready  out  1  registered; 1 = queue can accept (not full)
- rf_we  out  1  registered write enable to register file
- rf_waddr  out  REGW  registered write address
- rf_wdata  out  XLEN  registered write data
- q_empty  out  1  registered; queue empty (used by issue logic for drain-before-CSR)

Behaviour:
- Reset:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - Queue emptied: all valid and kill bits cleared, pointers 0.
  - Starvation counter 0, state IDLE.
  - lu_ready=1, q_empty=1, pipe_stall=0.
- Effective requests:
  - pipe request = pipe_we && pipe_rd!=0.
  - LU push occurs when lu_valid && lu_ready. A push with lu_rd==0 is accepted and discarded (never enqueued).
- Write latency: the winner in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1. rf_we=0 when no winner.
- State machine:
  - IDLE, queue empty.
    - Pipe request wins; pipe_stall=0.
    - Push moves the FSM to PEND next cycle.
  - PEND, queue non-empty.
    - If pipe request: pipe wins and the counter increments.
    - Else: head pops and wins (if head not killed) and the counter clears.
    - When the counter reaches MAX_WAIT, go to FORCE next cycle.
  - FORCE.
    - Head pops and wins. pipe_stall = pipe request (a pipe_we with rd==0 is never stalled).
    - Counter clears.
    - Next state: PEND if the queue is still non-empty after the pop/push, else IDLE.
  - Any pop in PEND that leaves the queue empty (no simultaneous push) goes to IDLE.
- Kill (WAW ordering): when a pipe write is granted to rd R, every valid queue entry with rd==R sets its kill bit.
  - A killed head pops in its normal slot with rf_we=0 and does not stall the pipeline in FORCE.
  - An entry pushed in the same cycle is not killed (LU result is younger).
- Queue:
  - Push and pop in the same cycle are both honoured, and the occupancy is unchanged.
  - lu_ready is computed from next-cycle occupancy (ready = occupancy_next < QDEPTH). Full in cycle N means ready=0 in N+1 even if a pop occurs in N+1.
  - Pointers wrap modulo QDEPTH.
- lu_valid while lu_ready=0: ignored; the LU must hold.
- Reset mid-operation: queued results are discarded without writing.

Optional Feature:
- Macro WB_ARB_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt (16 bits), a saturating count of cycles with pipe_stall=1. Cleared by rst; holds at 16'hFFFF.
  - Adds output perf_kill_cnt (16 bits), a saturating count of killed entries popped.
- Undefined: both ports and their counters are absent. Arbitration behaviour is identical either way.

Test Plan:
- Reset:
  - Stimulus: assert rst 2 cycles with lu_valid=1, pipe_we=1.
  - Response: rf_we=0, lu_ready=1, q_empty=1, pipe_stall=0 throughout; no write in the first cycle after release unless requested.
- Idle pipe write:
  - Stimulus: pipe_we=1, rd=5, data=32'hDEAD_BEEF, queue empty.
  - Response: next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEAD_BEEF, pipe_stall=0.
- Starvation:
  - Stimulus: push LU rd=7 data=32'h11, then pipe_we=1 continuously with rd=3.
  - Response: pipe wins 4 cycles; 5th cycle pipe_stall=1 and rd7/32'h11 is written next cycle; the pipe rd3 write follows the cycle after.
- Full queue:
  - Stimulus: two LU pushes while pipe_we=1 continuously.
  - Response: lu_ready=0 the cycle after the second push; a third lu_valid is held, not lost; lu_ready returns after a drain.
- Kill:
  - Stimulus: queue holds rd=9 data=32'hAA; pipe writes rd=9 data=32'hBB.
  - Response: register 9 receives only 32'hBB; the head pops later with rf_we=0.
- x0:
  - Stimulus: pipe_we=1 rd=0 during FORCE; LU push rd=0.
  - Response: pipe_stall=0, no rf_we for either, queue occupancy unchanged.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, LU results wait in an in-order queue.
// Optional build macro WB_ARB_PERF_EN adds saturating stall/kill performance counters.
module wb_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int REGW     = 5,
  parameter int QDEPTH   = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_we,
  input  logic [REGW-1:0] pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  output logic            pipe_stall,
  input  logic            lu_valid,
  input  logic [REGW-1:0] lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  output logic            rf_we,
  output logic [REGW-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            q_empty
`ifdef WB_ARB_PERF_EN
  ,
  output logic [15:0]     perf_stall_cnt,
  output logic [15:0]     perf_kill_cnt
`endif
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);
  localparam logic [CW-1:0] Q_FULL     = CW'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [WW-1:0]   wait_r, wait_nxt_s;
  logic [CW-1:0]   count_r, count_nxt_s;
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [REGW-1:0] q_rd_r   [QDEPTH];
  logic [XLEN-1:0] q_data_r [QDEPTH];
  logic [QDEPTH-1:0] q_vld_r;
  logic [QDEPTH-1:0] q_kill_r;

  logic            lu_ready_r, q_empty_r;
  logic            rf_we_r;
  logic [REGW-1:0] rf_waddr_r;
  logic [XLEN-1:0] rf_wdata_r;

  logic            pipe_req_s, push_s, push_keep_s;
  logic            pop_s, head_kill_s, pipe_grant_s, head_win_s, stall_s;
  logic [REGW-1:0] head_rd_s;
  logic [XLEN-1:0] head_data_s;

  // Effective requests and head-of-queue view
  always_comb begin
    pipe_req_s  = pipe_we && (pipe_rd != {REGW{1'b0}});
    push_s      = lu_valid && lu_ready_r;
    push_keep_s = push_s && (lu_rd != {REGW{1'b0}});
    head_kill_s = q_kill_r[rd_ptr_r];
    head_rd_s   = q_rd_r[rd_ptr_r];
    head_data_s = q_data_r[rd_ptr_r];
  end

  // Arbitration FSM: grants, pop, stall, starvation counter and next state
  always_comb begin
    state_nxt_s  = state_r;
    wait_nxt_s   = {WW{1'b0}};
    pop_s        = 1'b0;
    pipe_grant_s = 1'b0;
    head_win_s   = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      IDLE: begin
        pipe_grant_s = pipe_req_s;
      end
      PEND: begin
        if (pipe_req_s) begin
          pipe_grant_s = 1'b1;
          wait_nxt_s   = wait_r + WAIT_ONE;
        end else begin
          pop_s      = 1'b1;
          head_win_s = !head_kill_s;
        end
      end
      FORCE: begin
        pop_s = 1'b1;
        // A killed head frees the slot, so the pipeline is not held for it
        if (head_kill_s) begin
          pipe_grant_s = pipe_req_s;
        end else begin
          head_win_s = 1'b1;
          stall_s    = pipe_req_s;
        end
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase

    count_nxt_s = count_r + CW'(push_keep_s) - CW'(pop_s);

    if (count_nxt_s == {CW{1'b0}}) begin
      state_nxt_s = IDLE;
    end else if ((state_r == PEND) && pipe_req_s && (wait_nxt_s == WAIT_LIMIT)) begin
      state_nxt_s = FORCE;
    end else begin
      state_nxt_s = PEND;
    end
  end

  // State, queue storage and registered write-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      wait_r     <= {WW{1'b0}};
      count_r    <= {CW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      q_vld_r    <= {QDEPTH{1'b0}};
      q_kill_r   <= {QDEPTH{1'b0}};
      lu_ready_r <= 1'b1;
      q_empty_r  <= 1'b1;
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {REGW{1'b0}};
      rf_wdata_r <= {XLEN{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        q_rd_r[i]   <= {REGW{1'b0}};
        q_data_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      state_r    <= state_nxt_s;
      wait_r     <= wait_nxt_s;
      count_r    <= count_nxt_s;
      lu_ready_r <= (count_nxt_s < Q_FULL);
      q_empty_r  <= (count_nxt_s == {CW{1'b0}});
      rf_we_r    <= pipe_grant_s | head_win_s;

      if (pipe_grant_s) begin
        rf_waddr_r <= pipe_rd;
        rf_wdata_r <= pipe_data;
      end else if (head_win_s) begin
        rf_waddr_r <= head_rd_s;
        rf_wdata_r <= head_data_s;
      end else begin
        rf_waddr_r <= {REGW{1'b0}};
        rf_wdata_r <= {XLEN{1'b0}};
      end

      // Older queued results to the same register are superseded by the granted pipe write
      for (int i = 0; i < QDEPTH; i++) begin
        if (pipe_grant_s && q_vld_r[i] && (q_rd_r[i] == pipe_rd)) begin
          q_kill_r[i] <= 1'b1;
        end
      end

      if (pop_s) begin
        q_vld_r[rd_ptr_r]  <= 1'b0;
        q_kill_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r           <= rd_ptr_r + PTR_ONE;
      end

      if (push_keep_s) begin
        q_vld_r[wr_ptr_r]  <= 1'b1;
        q_kill_r[wr_ptr_r] <= 1'b0;
        q_rd_r[wr_ptr_r]   <= lu_rd;
        q_data_r[wr_ptr_r] <= lu_data;
        wr_ptr_r           <= wr_ptr_r + PTR_ONE;
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [15:0] perf_stall_r, perf_kill_r;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_r <= 16'h0000;
      perf_kill_r  <= 16'h0000;
    end else begin
      if (stall_s && (perf_stall_r != 16'hFFFF)) begin
        perf_stall_r <= perf_stall_r + 16'h0001;
      end
      if (pop_s && head_kill_s && (perf_kill_r != 16'hFFFF)) begin
        perf_kill_r <= perf_kill_r + 16'h0001;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_r;
  assign perf_kill_cnt  = perf_kill_r;
`endif

  assign pipe_stall = stall_s && !rst;
  assign lu_ready   = lu_ready_r;
  assign q_empty    = q_empty_r;
  assign rf_we      = rf_we_r;
  assign rf_waddr   = rf_waddr_r;
  assign rf_wdata   = rf_wdata_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, corner sequences, random run against a queue model.
module tb_wb_port_arbiter;

  localparam int XLEN     = 32;
  localparam int REGW     = 5;
  localparam int QDEPTH   = 2;
  localparam int MAX_WAIT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            pipe_we;
  logic [REGW-1:0] pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            pipe_stall;
  logic            lu_valid;
  logic [REGW-1:0] lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            lu_ready;
  logic            rf_we;
  logic [REGW-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            q_empty;
`ifdef WB_ARB_PERF_EN
  logic [15:0]     perf_stall_cnt;
  logic [15:0]     perf_kill_cnt;
`endif

  wb_port_arbiter #(.XLEN(XLEN), .REGW(REGW), .QDEPTH(QDEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .q_empty(q_empty)
`ifdef WB_ARB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_kill_cnt(perf_kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: the LU queue as a list of pending results plus starvation bookkeeping
  typedef struct {
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
    bit              kill;
  } ent_t;

  ent_t            mq[$];
  int              m_wait;
  bit              m_force;
  bit              m_ready, m_empty, m_we;
  logic [REGW-1:0] m_waddr;
  logic [XLEN-1:0] m_wdata;

  typedef struct {
    bit r; bit pwe; logic [4:0] prd; logic [31:0] pd;
    bit lv; logic [4:0] lrd; logic [31:0] ld;
    bit e_stall; bit e_we; logic [4:0] e_addr; logic [31:0] e_data;
    bit e_ready; bit e_empty; bit chk_ad;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_stall();
    if (rst || !m_force || (mq.size() == 0)) return 1'b0;
    return pipe_we && (pipe_rd != 5'd0) && !mq[0].kill;
  endfunction

  task automatic model_check();
    chk("m_stall", {31'd0, pipe_stall}, {31'd0, model_stall()});
    chk("m_we", {31'd0, rf_we}, {31'd0, m_we});
    if (m_we) begin
      chk("m_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
      chk("m_wdata", rf_wdata, m_wdata);
    end
    chk("m_ready", {31'd0, lu_ready}, {31'd0, m_ready});
    chk("m_empty", {31'd0, q_empty}, {31'd0, m_empty});
  endtask

  task automatic model_step();
    bit preq, push, pop, gp, gh, had_entries;
    ent_t head, e;
    if (rst) begin
      mq.delete();
      m_wait = 0; m_force = 1'b0; m_ready = 1'b1; m_empty = 1'b1;
      m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
      return;
    end
    preq = pipe_we && (pipe_rd != 5'd0);
    push = lu_valid && m_ready;
    pop = 1'b0; gp = 1'b0; gh = 1'b0;
    had_entries = (mq.size() > 0);
    head = had_entries ? mq[0] : '{rd: 5'd0, data: 32'd0, kill: 1'b0};
    if (m_force) begin
      pop = 1'b1;
      if (head.kill) gp = preq; else gh = 1'b1;
    end else if (had_entries) begin
      if (preq) gp = 1'b1;
      else begin pop = 1'b1; gh = !head.kill; end
    end else begin
      gp = preq;
    end
    m_we = gp || gh;
    m_waddr = gp ? pipe_rd : head.rd;
    m_wdata = gp ? pipe_data : head.data;
    if (pop) void'(mq.pop_front());
    if (gp) begin
      foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].kill = 1'b1;
    end
    if (push && (lu_rd != 5'd0)) begin
      e.rd = lu_rd; e.data = lu_data; e.kill = 1'b0;
      mq.push_back(e);
    end
    if (!m_force && had_entries && preq) m_wait = m_wait + 1;
    else m_wait = 0;
    m_force = !m_force && had_entries && preq && (m_wait == MAX_WAIT);
    if (mq.size() == 0) m_force = 1'b0;
    m_ready = (mq.size() < QDEPTH);
    m_empty = (mq.size() == 0);
  endtask

  task automatic drive(input bit r, input bit pwe, input logic [4:0] prd, input logic [31:0] pd,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
    rst = r; pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    bit seen;
    bit r, pwe, lv;
    logic [4:0] prd, lrd;
    int k;

    tbl[0]  = '{1'b1, 1'b1, 5'd5, 32'h1234,      1'b1, 5'd7, 32'h99, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 5'd5, 32'h1234,      1'b1, 5'd7, 32'h99, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 32'h11, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 5'd3, 32'h33,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 5'd3, 32'h34,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd3, 32'h33,        1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 5'd3, 32'h35,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd3, 32'h34,        1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 5'd3, 32'h36,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd3, 32'h35,        1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 5'd3, 32'h37,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd3, 32'h36,        1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 5'd3, 32'h37,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd7, 32'h11,        1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd3, 32'h37,        1'b1, 1'b1, 1'b1};

    rst = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1234;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h99;
    tick();

    // Reset, idle write and starvation-forced drain
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].r, tbl[i].pwe, tbl[i].prd, tbl[i].pd, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
      chk("t_stall", {31'd0, pipe_stall}, {31'd0, tbl[i].e_stall});
      chk("t_we", {31'd0, rf_we}, {31'd0, tbl[i].e_we});
      if (tbl[i].chk_ad) begin
        chk("t_waddr", {27'd0, rf_waddr}, {27'd0, tbl[i].e_addr});
        chk("t_wdata", rf_wdata, tbl[i].e_data);
      end
      chk("t_ready", {31'd0, lu_ready}, {31'd0, tbl[i].e_ready});
      chk("t_empty", {31'd0, q_empty}, {31'd0, tbl[i].e_empty});
      tick();
    end

    // Full queue: third result is held while lu_ready is low, then accepted
    drive(1'b0, 1'b1, 5'd3, 32'd1, 1'b1, 5'd10, 32'hA0); tick();
    drive(1'b0, 1'b1, 5'd3, 32'd2, 1'b1, 5'd11, 32'hA1); tick();
    drive(1'b0, 1'b1, 5'd3, 32'd3, 1'b1, 5'd12, 32'hA2);
    chk("full_ready_low", {31'd0, lu_ready}, 32'd0); tick();
    drive(1'b0, 1'b1, 5'd3, 32'd3, 1'b1, 5'd12, 32'hA2); tick();
    drive(1'b0, 1'b1, 5'd3, 32'd3, 1'b1, 5'd12, 32'hA2); tick();
    drive(1'b0, 1'b1, 5'd3, 32'd3, 1'b1, 5'd12, 32'hA2);
    chk("full_force_stall", {31'd0, pipe_stall}, 32'd1); tick();
    drive(1'b0, 1'b1, 5'd3, 32'd3, 1'b1, 5'd12, 32'hA2);
    chk("full_ready_back", {31'd0, lu_ready}, 32'd1);
    chk("full_head_addr", {27'd0, rf_waddr}, 32'd10);
    chk("full_head_data", rf_wdata, 32'hA0); tick();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      if (rf_we && (rf_waddr == 5'd12) && (rf_wdata == 32'hA2)) seen = 1'b1;
      tick();
    end
    chk("full_held_entry", {31'd0, seen}, 32'd1);

    // Kill: younger pipe write to r9 supersedes the queued LU result
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hAA); tick();
    drive(1'b0, 1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'd0); tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("kill_we", {31'd0, rf_we}, 32'd1);
    chk("kill_addr", {27'd0, rf_waddr}, 32'd9);
    chk("kill_data", rf_wdata, 32'hBB); tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("kill_no_write", {31'd0, rf_we}, 32'd0);
    chk("kill_empty", {31'd0, q_empty}, 32'd1); tick();

    // x0: rd==0 pipe write during FORCE is not stalled, rd==0 push is dropped
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'h13); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 5'd3, 32'h40 + 32'(i), 1'b0, 5'd0, 32'd0); tick();
    end
    drive(1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h77);
    chk("x0_no_stall", {31'd0, pipe_stall}, 32'd0); tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("x0_head_addr", {27'd0, rf_waddr}, 32'd13);
    chk("x0_head_data", rf_wdata, 32'h13);
    chk("x0_empty", {31'd0, q_empty}, 32'd1); tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("x0_no_write", {31'd0, rf_we}, 32'd0); tick();

    // Random traffic with occasional mid-operation reset
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      pwe = ($urandom_range(0, 9) < 7);
      k   = $urandom_range(0, 5);
      prd = (k == 5) ? 5'($urandom) : 5'(k);
      lv  = ($urandom_range(0, 1) == 1);
      k   = $urandom_range(0, 5);
      lrd = (k == 5) ? 5'($urandom) : 5'(k);
      drive(r, pwe, prd, $urandom, lv, lrd, $urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
